// File: rtl/cpu_port_responder.sv
// Cycle-timed stand-in for the SDRAM controller CPU port: the same request handshake,
// power-up delay and refresh stalls, backed by an on-chip word memory.
module cpu_port_responder #(
  parameter int ADDR_W         = 8,
  parameter int INIT_CYCLES    = 40960,
  parameter int WR_LAT         = 6,
  parameter int RD_LAT         = 8,
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_adv,
  input  logic        i_rwn,
  input  logic [26:0] i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_busy,
  output logic        o_ack,
  output logic        o_init_done,
  output logic        o_err
);

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_ACCESS  = 2'd2;
  localparam logic [1:0] ST_REFRESH = 2'd3;

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);
  localparam int REF_W = $clog2(REFRESH_PERIOD);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic              ref_pend_q, ref_pend_d;
  logic              rwn_q, rwn_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic              ack_q, ack_d;
  logic              init_done_q, init_done_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              ref_wrap;
  logic              acc_last;

  logic [31:0] mem_q [2**ADDR_W];

  // Address bits above the word index alias onto the same word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_addr[26:ADDR_W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ref_cnt_d   = ref_cnt_q;
    ref_pend_d  = ref_pend_q;
    rwn_d       = rwn_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    ack_d       = 1'b0;
    init_done_d = init_done_q;
    err_d       = err_q;
    mem_we      = 1'b0;

    // Refresh timebase starts at init done and keeps running in every state.
    ref_wrap = init_done_q && (ref_cnt_q == REF_W'(REFRESH_PERIOD - 1));
    if (init_done_q) begin
      ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    end
    if (ref_wrap) begin
      ref_pend_d = 1'b1;
    end

    if (i_adv && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end

    acc_last = rwn_q ? (cnt_q == CNT_W'(RD_LAT - 2)) : (cnt_q == CNT_W'(WR_LAT - 2));

    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        // A request presented in the same cycle as a due refresh takes priority.
        if (i_adv) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
          rwn_d   = i_rwn;
          idx_d   = i_addr[ADDR_W-1:0];
          wdata_d = i_data;
        end else if (ref_pend_q) begin
          state_d = ST_REFRESH;
          cnt_d   = '0;
        end
      end
      ST_ACCESS: begin
        if (acc_last) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          cnt_d   = '0;
          if (rwn_q) begin
            data_d = mem_q[idx_q];
          end else begin
            mem_we = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == CNT_W'(REFRESH_CYCLES - 1)) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          ref_pend_d = ref_wrap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ref_cnt_q   <= '0;
      ref_pend_q  <= 1'b0;
      rwn_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      ack_q       <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      rwn_q       <= rwn_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  // Memory survives reset; a write is only committed on its completion cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign o_data      = data_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_ack       = ack_q;
  assign o_init_done = init_done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_cpu_port_responder.sv
// Directed bench for cpu_port_responder: requests push expected acks to a queue,
// the per-cycle monitor pops and compares them against cycle-accurate due times.
module tb_cpu_port_responder;

  localparam int INIT_CYCLES = 40960;
  localparam int WR_LAT      = 6;
  localparam int RD_LAT      = 8;
  localparam int REF_PERIOD  = 780;
  localparam int REF_CYCLES  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        adv;
  logic        rwn;
  logic [26:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        ack;
  logic        init_done;
  logic        err;

  cpu_port_responder dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_adv       (adv),
    .i_rwn       (rwn),
    .i_addr      (addr),
    .i_data      (wdata),
    .o_data      (rdata),
    .o_busy      (busy),
    .o_ack       (ack),
    .o_init_done (init_done),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          due;
    logic [7:0]  idx;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [256];
  int          cyc;
  int          vectors;
  int          miscompares;
  int          ack_seen;
  int          mon_bad;
  bit          mon_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (ack === 1'b1) begin
      ack_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_cycle", 32'(cyc), 32'(e.due));
        if (e.rd) chk("rd_data", rdata, e.data);
        else model[e.idx] = e.data;
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      chk("ack_missing", 32'(cyc), 32'(e.due));
    end
    if (mon_en && (busy !== ~ack)) mon_bad++;
  endtask

  task automatic req(input logic r, input logic [26:0] a, input logic [31:0] d);
    exp_t e;
    adv   = 1'b1;
    rwn   = r;
    addr  = a;
    wdata = d;
    e.rd   = r;
    e.idx  = a[7:0];
    e.due  = cyc + (r ? RD_LAT : WR_LAT);
    e.data = r ? model[a[7:0]] : d;
    sb.push_back(e);
    tick();
    adv = 1'b0;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_init(input string tag);
    int bad;
    bad = 0;
    while (cyc < INIT_CYCLES) begin
      if (busy !== 1'b1 || init_done !== 1'b0) bad++;
      tick();
    end
    chk({tag, "_busy_during_init"}, 32'(bad), 32'd0);
    chk({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
    chk({tag, "_busy_after_init"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int t0;
    int base_acks;
    vectors     = 0;
    miscompares = 0;
    ack_seen    = 0;
    mon_bad     = 0;
    mon_en      = 1'b0;
    cyc         = 0;
    rst_n       = 1'b0;
    adv         = 1'b0;
    rwn         = 1'b0;
    addr        = '0;
    wdata       = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_data", rdata, 32'd0);

    // Power-up delay
    rst_n = 1'b1;
    cyc   = 0;
    run_init("init1");
    chk("init_err", {31'd0, err}, 32'd0);
    t0 = cyc;

    // Writes, reads and an aliased read
    req(1'b0, 27'h20, 32'h0000_0055);
    wait_ack();
    req(1'b0, 27'h38, 32'h0000_00AA);
    wait_ack();
    req(1'b1, 27'h20, 32'h0);
    wait_ack();
    req(1'b1, 27'h38, 32'h0);
    wait_ack();
    req(1'b1, 27'h400_0020, 32'h0);
    wait_ack();

    // Request arriving while busy is dropped
    req(1'b0, 27'h05, 32'h0000_0077);
    tick();
    adv   = 1'b1;
    rwn   = 1'b0;
    addr  = 27'h06;
    wdata = 32'hFFFF_FFFF;
    tick();
    adv = 1'b0;
    chk("err_set", {31'd0, err}, 32'd1);
    wait_ack();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Back-to-back reads issued on each ack cycle
    req(1'b1, 27'h20, 32'h0);
    mon_en = 1'b1;
    wait_ack();
    req(1'b1, 27'h38, 32'h0);
    wait_ack();
    req(1'b1, 27'h05, 32'h0);
    wait_ack();
    req(1'b1, 27'h20, 32'h0);
    wait_ack();
    mon_en = 1'b0;
    chk("b2b_busy_only_off_on_ack", 32'(mon_bad), 32'd0);

    // Request on the cycle the refresh becomes due
    while (cyc < t0 + REF_PERIOD) tick();
    chk("pre_collision_busy", {31'd0, busy}, 32'd0);
    req(1'b0, 27'h40, 32'h0000_0099);
    wait_ack();
    chk("collision_ack_cycle", 32'(cyc), 32'(t0 + REF_PERIOD + WR_LAT));
    chk("wr_ack_keeps_data", rdata, 32'h0000_0055);
    mon_bad = 0;
    for (int i = 0; i < REF_CYCLES; i++) begin
      tick();
      if (busy !== 1'b1) mon_bad++;
    end
    chk("refresh_busy", 32'(mon_bad), 32'd0);
    tick();
    chk("refresh_done_busy", {31'd0, busy}, 32'd0);
    req(1'b1, 27'h40, 32'h0);
    wait_ack();

    // Reset in the middle of a write
    req(1'b0, 27'h10, 32'hDEAD_BEEF);
    wait_ack();
    req(1'b0, 27'h10, 32'h1234_5678);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    cyc = 0;
    base_acks = ack_seen;
    chk("rst2_busy", {31'd0, busy}, 32'd1);
    chk("rst2_init_done", {31'd0, init_done}, 32'd0);
    chk("rst2_err", {31'd0, err}, 32'd0);
    chk("rst2_data", rdata, 32'd0);
    run_init("init2");
    chk("no_ack_after_abort", 32'(ack_seen - base_acks), 32'd0);
    req(1'b1, 27'h10, 32'h0);
    wait_ack();
    chk("aborted_write_not_committed", rdata, 32'hDEAD_BEEF);
    chk("rst2_err_after", {31'd0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_port_responder.md
Name: cpu_port_responder

Overview:
- Cycle-timed stand-in for the SDRAM controller's CPU-side port, so CPU-side initiators (test sequencers, bus masters) can be brought up and verified without the physical SDRAM.
- Responds to the same i_adv/i_rwn/i_addr/i_data request protocol and returns o_busy/o_ack/o_data/o_init_done, including the controller's power-up delay and periodic refresh stalls.
- Backed by an on-chip 32-bit word memory.
- Sits in place of the controller instance in top-level test builds.

Parameters:
- ADDR_W, 8, memory depth is 2^ADDR_W words; word index = i_addr[ADDR_W-1:0], upper address bits ignored.
- INIT_CYCLES, 40960, cycles from reset release to o_init_done=1.
- WR_LAT, 6, cycles from accepted write request to o_ack.
- RD_LAT, 8, cycles from accepted read request to o_ack.
- REFRESH_PERIOD, 780, cycles between refresh stalls; counting starts at init done.
- REFRESH_CYCLES, 8, duration of each refresh stall.

Ports:
- i_clk  input  1  single clock, all logic on its rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_adv  input  1  request strobe, single-cycle pulse.
- i_rwn  input  1  1 = read, 0 = write; sampled with i_adv.
- i_addr  input  27  request address; sampled with i_adv.
- i_data  input  32  write data; sampled with i_adv.
- o_data  output  32  read data.
- o_busy  output  1  request cannot be accepted.
- o_ack  output  1  one-cycle completion pulse.
- o_init_done  output  1  init delay elapsed; stays high until reset.
- o_err  output  1  sticky: a request was dropped.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - o_data=0, o_busy=1, o_ack=0, o_init_done=0, o_err=0.
  - State returns to INIT; all counters cleared.
  - Memory contents are not cleared.
  - Reset mid-access aborts the access: no o_ack; a pending write is not committed.
- States: INIT, IDLE, ACCESS, REFRESH.
- INIT:
  - o_busy=1; counts INIT_CYCLES.
  - On the cycle the count completes: o_init_done=1, o_busy=0, state goes to IDLE, refresh counter starts at 0.
- Acceptance:
  - A request is accepted when i_adv=1 in IDLE with o_busy=0.
  - At acceptance, address, data and rwn are latched.
  - o_busy=1 from the next cycle.
- ACCESS (request accepted at cycle N):
  - Write: memory written with the latched data at cycle N+WR_LAT-1; o_ack=1 at cycle N+WR_LAT.
  - Read: o_data updated and o_ack=1 at cycle N+RD_LAT.
  - o_data holds its value until the next read ack; write acks leave o_data unchanged.
  - o_busy returns to 0 on the ack cycle. A new i_adv on the ack cycle is accepted (back-to-back allowed).
- Dropped requests: i_adv=1 while o_busy=1, in any state including INIT, is ignored and sets o_err=1. o_err clears only on reset.
- Refresh:
  - Free-running counter wraps at REFRESH_PERIOD-1; the wrap sets refresh_pending.
  - In IDLE with refresh_pending: go to REFRESH, o_busy=1 for exactly REFRESH_CYCLES cycles, then IDLE with pending cleared.
  - If i_adv=1 in the same cycle the refresh becomes due while IDLE: the access wins and the refresh stays pending.
  - Refresh due during ACCESS is deferred. It starts the cycle after the ack, unless a back-to-back request was accepted on the ack cycle; in that case it waits for that access to ack.
  - The refresh counter keeps running during REFRESH and ACCESS. A second wrap while a refresh is already pending is merged (no queueing).
- o_ack is never asserted in INIT or REFRESH.
- Read after write to the same index returns the written data.
- Addresses differing only above bit ADDR_W-1 alias to the same word.

Test Plan:
- Reset release -> o_busy=1 and o_init_done=0 through cycle 40959; o_init_done=1 and o_busy=0 at cycle 40960; o_err=0.
- Write 0x00000055 to addr 0x20, then write 0x000000AA to 0x38, then read 0x20 and read 0x38 -> each write acks exactly 6 cycles after its i_adv; reads ack exactly 8 cycles after i_adv with o_data=0x00000055 and 0x000000AA respectively.
- i_adv pulse 2 cycles after an accepted write -> request ignored, o_err=1 and stays 1; the original write still acks at +6.
- Refresh collision: i_adv on the cycle the refresh becomes due -> access acks on schedule; o_busy stays 1 for 8 further cycles after the ack; the next request is accepted only after that.
- Back-to-back reads: new i_adv on each ack cycle, 4 reads, no refresh due -> acks spaced exactly 8 cycles apart; o_busy is 0 only on the ack cycles.
- i_rst_n=0 for one cycle, 3 cycles after an accepted write to 0x10 holding 0x12345678 (old value 0xDEADBEEF) -> no ack; INIT re-runs (o_init_done=0); read of 0x10 after init returns 0xDEADBEEF; o_err=0.
